data_transmission_unit_ser: RTL

Synthesisable, parametrised transmit serialiser between the 32-bit TX FIFO and the chip's serial output lanes. Runs entirely on the fast serial clock. Fetches words from the FIFO with an active-low read strobe and prefetches so back-to-back words leave with no gaps. Shifts each word out over `LANES` parallel lanes, sends a programmable idle word when no data is available, and flags word boundaries and idle state for the link layer.

---
 rtl/data_transmission_unit_ser.sv | 83 ++++++++
 1 files changed

// File: rtl/data_transmission_unit_ser.sv
// Serialises FIFO words onto LANES output bits, one word per N cycles, idle word when starved.
// FIFO data reaches ser_data_o 3 cycles after the read strobe; the FIFO is read at most once per word.
module data_transmission_unit_ser #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LANES      = 1,
    parameter bit                    MSB_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 32'hBCBC_BCBC
) (
    input  logic                  clk640MHz_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] tx_fifo_rdata_i,
    input  logic                  tx_fifo_empty_i,
    output logic                  tx_fifo_rd_n_o,
    output logic [LANES-1:0]      ser_data_o,
    output logic                  word_start_o,
    output logic                  idle_o,
    output logic [15:0]           word_cnt_o
);

    localparam int N  = DATA_WIDTH / LANES;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] SLICE_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] SLICE_FETCH = CW'(N - 3);

    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_pend;
    logic                  r_idle;
    logic [15:0]           r_word_cnt;

    logic                  w_boundary;
    logic                  w_fetch;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_boundary = (r_bit_cnt == SLICE_LAST);
    // The fetch slot sits two cycles before the boundary so the word is held in time to load.
    assign w_fetch    = (r_bit_cnt == SLICE_FETCH) && enable_i && !tx_fifo_empty_i && !r_pend;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted  = {r_shift[DATA_WIDTH-LANES-1:0], {LANES{1'b0}}};
            assign ser_data_o = r_shift[DATA_WIDTH-1 -: LANES];
        end else begin : g_lsb
            assign w_shifted  = {{LANES{1'b0}}, r_shift[DATA_WIDTH-1:LANES]};
            assign ser_data_o = r_shift[LANES-1:0];
        end
    endgenerate

    always_ff @(posedge clk640MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bit_cnt  <= SLICE_LAST;
            r_shift    <= '0;
            r_hold     <= '0;
            r_pend     <= 1'b0;
            r_idle     <= 1'b1;
            r_word_cnt <= 16'd0;
        end else begin
            r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + CW'(1);
            if (w_fetch) begin
                r_hold <= tx_fifo_rdata_i;
                r_pend <= 1'b1;
            end
            if (w_boundary) begin
                r_shift <= r_pend ? r_hold : IDLE_WORD;
                r_idle  <= !r_pend;
                r_pend  <= 1'b0;
                if (r_pend) begin
                    r_word_cnt <= r_word_cnt + 16'd1;
                end
            end else begin
                r_shift <= w_shifted;
            end
        end
    end

    assign tx_fifo_rd_n_o = !w_fetch;
    assign word_start_o   = (r_bit_cnt == '0) && rst_n_i;
    assign idle_o         = r_idle;
    assign word_cnt_o     = r_word_cnt;

endmodule
